// File: rtl/register_write_arbiter_if.sv
// Write-port bundle between the two writeback requesters, the register file and the read stage.
interface register_write_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    localparam int unsigned STALL_WIDTH = 8;

    logic                   Req0_Valid;
    logic [ADDR_WIDTH-1:0]  Req0_Register;
    logic [DATA_WIDTH-1:0]  Req0_Data;
    logic                   Req0_Ready;

    logic                   Req1_Valid;
    logic [ADDR_WIDTH-1:0]  Req1_Register;
    logic [DATA_WIDTH-1:0]  Req1_Data;
    logic                   Req1_Ready;

    logic                   RegWrite;
    logic [ADDR_WIDTH-1:0]  Write_Register;
    logic [DATA_WIDTH-1:0]  Write_Data;

    logic [ADDR_WIDTH-1:0]  Read_Register1;
    logic [ADDR_WIDTH-1:0]  Read_Register2;
    logic                   Bypass1;
    logic                   Bypass2;
    logic [DATA_WIDTH-1:0]  Bypass_Data;

    logic [STALL_WIDTH-1:0] Stall_Count;

    // Requesters and read stage side
    modport master (
        output Req0_Valid, Req0_Register, Req0_Data,
        output Req1_Valid, Req1_Register, Req1_Data,
        output Read_Register1, Read_Register2,
        input  Req0_Ready, Req1_Ready,
        input  RegWrite, Write_Register, Write_Data,
        input  Bypass1, Bypass2, Bypass_Data, Stall_Count
    );

    // Arbiter side
    modport slave (
        input  Req0_Valid, Req0_Register, Req0_Data,
        input  Req1_Valid, Req1_Register, Req1_Data,
        input  Read_Register1, Read_Register2,
        output Req0_Ready, Req1_Ready,
        output RegWrite, Write_Register, Write_Data,
        output Bypass1, Bypass2, Bypass_Data, Stall_Count
    );
endinterface

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter merging ALU and load writebacks into one register-file write port,
// with same-cycle bypass flags and a saturating lost-arbitration counter.
module register_write_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input logic                    Clock,
    input logic                    Reset,
    register_write_arbiter_if.slave bus
);
    localparam int unsigned STALL_WIDTH = 8;
    localparam logic [STALL_WIDTH-1:0] STALL_MAX = '1;

    logic                   grant0_c;
    logic                   grant1_c;
    logic                   accept_c;
    logic                   stall_c;
    logic [ADDR_WIDTH-1:0]  sel_register_c;
    logic [DATA_WIDTH-1:0]  sel_data_c;

    // 1 when requester 1 won most recently; reset value hands priority to requester 0
    logic                   last_grant;
    logic                   regwrite_q;
    logic [ADDR_WIDTH-1:0]  write_register_q;
    logic [DATA_WIDTH-1:0]  write_data_q;
    logic [STALL_WIDTH-1:0] stall_count_q;

    // Grant: a lone requester always wins, contention goes to the one not granted last
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (!Reset) begin
            grant0_c = bus.Req0_Valid && (!bus.Req1_Valid || last_grant);
            grant1_c = bus.Req1_Valid && (!bus.Req0_Valid || !last_grant);
        end
    end

    // Payload of the granted requester plus accept/stall qualifiers
    always_comb begin
        accept_c       = grant0_c || grant1_c;
        stall_c        = (bus.Req0_Valid && !grant0_c) || (bus.Req1_Valid && !grant1_c);
        sel_register_c = grant1_c ? bus.Req1_Register : bus.Req0_Register;
        sel_data_c     = grant1_c ? bus.Req1_Data     : bus.Req0_Data;
    end

    // Write stage: register 0 is accepted and latched but never enabled for writing
    always_ff @(posedge Clock) begin
        if (Reset) begin
            regwrite_q       <= 1'b0;
            write_register_q <= '0;
            write_data_q     <= '0;
            last_grant       <= 1'b1;
        end else begin
            regwrite_q <= accept_c && (sel_register_c != '0);
            if (accept_c) begin
                write_register_q <= sel_register_c;
                write_data_q     <= sel_data_c;
                last_grant       <= grant1_c;
            end
        end
    end

    // Saturating count of cycles in which a valid requester was refused
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stall_count_q <= '0;
        end else if (stall_c && (stall_count_q != STALL_MAX)) begin
            stall_count_q <= stall_count_q + STALL_WIDTH'(1);
        end
    end

    assign bus.Req0_Ready     = grant0_c;
    assign bus.Req1_Ready     = grant1_c;
    assign bus.RegWrite       = regwrite_q;
    assign bus.Write_Register = write_register_q;
    assign bus.Write_Data     = write_data_q;
    assign bus.Bypass1        = regwrite_q && (write_register_q == bus.Read_Register1);
    assign bus.Bypass2        = regwrite_q && (write_register_q == bus.Read_Register2);
    assign bus.Bypass_Data    = write_data_q;
    assign bus.Stall_Count    = stall_count_q;
endmodule
